// File: rtl/vector_pkg.sv
// Shared lane-count, bf16 width and sequencer state type for the vector exp path.
package vector_pkg;

  localparam int NUM_LANES = 16;
  localparam int BF16_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vexp_seq_state_t;

endpackage

// File: rtl/vexp_seq.sv
// Feeds up to NUM_LANES bf16 elements one per cycle into a pipelined exp unit and
// gathers the results, in issue order, into a vector held until the consumer takes it.
module vexp_seq
  import vector_pkg::*;
#(
  parameter int NUM_LANES = vector_pkg::NUM_LANES,
  parameter int DW        = BF16_W
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [NUM_LANES*DW-1:0]       req_vec,
  input  logic [$clog2(NUM_LANES):0]    req_len,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [NUM_LANES*DW-1:0]       resp_vec,
  output logic [DW-1:0]                 vx_operand,
  output logic                          vx_valid_in,
  input  logic                          vx_ready_in,
  input  logic [DW-1:0]                 vx_result,
  input  logic                          vx_valid_out,
  output logic                          vx_ready_out
);

  localparam int IW = $clog2(NUM_LANES) + 1;
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IW-1:0] LANES_N = IW'(NUM_LANES);

  vexp_seq_state_t         state_q, state_d;
  logic [NUM_LANES*DW-1:0] vec_q, vec_d;
  logic [NUM_LANES*DW-1:0] buf_q, buf_d;
  logic [IW-1:0]           n_q, n_d;
  logic [IW-1:0]           iss_q, iss_d;
  logic [IW-1:0]           res_q, res_d;
  logic [LW-1:0]           iss_lane, res_lane;

  assign iss_lane = iss_q[LW-1:0];
  assign res_lane = res_q[LW-1:0];
  assign resp_vec = buf_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      vec_q   <= '0;
      buf_q   <= '0;
      n_q     <= '0;
      iss_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      buf_q   <= buf_d;
      n_q     <= n_d;
      iss_q   <= iss_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    buf_d        = buf_q;
    n_d          = n_q;
    iss_d        = iss_q;
    res_d        = res_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    vx_valid_in  = 1'b0;
    vx_ready_out = 1'b0;
    vx_operand   = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          vec_d   = req_vec;
          n_d     = (req_len > LANES_N) ? LANES_N : req_len;
          iss_d   = '0;
          res_d   = '0;
          buf_d   = '0;
          state_d = (n_d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        vx_ready_out = 1'b1;
        vx_valid_in  = (iss_q < n_q);
        if (vx_valid_in) begin
          vx_operand = vec_q[iss_lane*DW +: DW];
        end
        if (vx_valid_in && vx_ready_in) begin
          iss_d = iss_q + IW'(1);
        end
        // A result with nothing outstanding cannot belong to this request; drop it.
        if (vx_valid_out && (res_q < iss_q)) begin
          buf_d[res_lane*DW +: DW] = vx_result;
          res_d = res_q + IW'(1);
          if (res_d == n_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vexp_seq.sv
// Bench for vexp_seq: 3-cycle behavioural exp unit, vector table, corner sequences, random run.
module tb_vexp_seq;
  import vector_pkg::*;

  localparam int NL = 16;
  localparam int DW = 16;
  localparam int VW = NL * DW;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [VW-1:0] req_vec = '0;
  logic [4:0]    req_len = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [VW-1:0] resp_vec;
  logic [DW-1:0] vx_operand;
  logic          vx_valid_in;
  logic          vx_ready_in = 1'b1;
  logic [DW-1:0] vx_result = '0;
  logic          vx_valid_out = 1'b0;
  logic          vx_ready_out;

  always #5 CLK = ~CLK;

  vexp_seq #(.NUM_LANES(NL), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec), .req_len(req_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_vec(resp_vec),
    .vx_operand(vx_operand), .vx_valid_in(vx_valid_in), .vx_ready_in(vx_ready_in),
    .vx_result(vx_result), .vx_valid_out(vx_valid_out), .vx_ready_out(vx_ready_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // bf16 -> real, exp(), round-to-nearest-even back to bf16.
  function automatic logic [15:0] bf16_exp(input logic [15:0] x);
    real        v, e;
    logic [63:0] b;
    int         ex;
    logic [7:0] m8;
    ex = int'(x[14:7]);
    if (ex == 0) v = 0.0;
    else v = (1.0 + real'(x[6:0]) / 128.0) * $pow(2.0, real'(ex - 127));
    if (x[15]) v = -v;
    e  = $exp(v);
    b  = $realtobits(e);
    ex = int'(b[62:52]) - 1023 + 127;
    if (ex >= 255) return 16'h7F80;
    if (ex <= 0) return 16'h0000;
    m8 = {1'b0, b[51:45]};
    if (b[44] && ((|b[43:0]) || m8[0])) m8 = m8 + 8'd1;
    if (m8[7]) begin
      m8 = 8'd0;
      ex = ex + 1;
      if (ex >= 255) return 16'h7F80;
    end
    return {1'b0, 8'(ex), m8[6:0]};
  endfunction

  function automatic logic [VW-1:0] ref_resp(input logic [VW-1:0] v, input int n);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++)
      if (i < n) r[i*DW +: DW] = bf16_exp(v[i*DW +: DW]);
    return r;
  endfunction

  // ---------------- exp unit model and event log ----------------
  typedef struct {
    logic [15:0] r;
    int          t;
  } ent_t;
  ent_t q[$];

  int   cyc = 0;
  int   n_iss = 0, n_cap = 0, hs_cyc = 0, first_iss = -1, last_iss = 0, last_cap = 0;
  bit   rand_rdy = 1'b0, stall_en = 1'b0, spur_req = 1'b0, spur_now = 1'b0;
  int   stall_cnt = 0;
  bit   stall_chk_en = 1'b0;
  logic [15:0] stall_val = '0;

  always @(posedge CLK) begin : exp_model
    bit iss, cap, hs;
    iss = vx_valid_in && vx_ready_in;
    cap = vx_valid_out && vx_ready_out && !spur_now;
    hs  = req_valid && req_ready;
    if (!nRST) begin
      q.delete();
      stall_cnt = 0;
    end else begin
      if (hs) begin
        n_iss = 0; n_cap = 0; hs_cyc = cyc; first_iss = -1;
      end
      if (cap) begin
        if (q.size() > 0) q.delete(0);
        n_cap++;
        last_cap = cyc;
      end
      if (iss) begin
        q.push_back('{bf16_exp(vx_operand), cyc + 3});
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
        n_iss++;
        if (stall_en && n_iss == 2) begin
          stall_cnt = 4;
          stall_en  = 1'b0;
        end
      end
    end
    cyc++;
    #1;
    spur_now = 1'b0;
    if (spur_req) begin
      vx_valid_out = 1'b1; vx_result = 16'hDEAD; spur_now = 1'b1; spur_req = 1'b0;
    end else if (q.size() > 0 && q[0].t <= cyc) begin
      vx_valid_out = 1'b1; vx_result = q[0].r;
    end else begin
      vx_valid_out = 1'b0; vx_result = 16'h0;
    end
    if (stall_cnt > 0) begin
      vx_ready_in = 1'b0;
      stall_cnt--;
    end else begin
      vx_ready_in = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  always @(negedge CLK)
    if (stall_chk_en && !vx_ready_in)
      chk("stall_hold", {vx_valid_in, vx_operand}, {1'b1, stall_val});

  // ---------------- request driver ----------------
  task automatic run_req(input logic [VW-1:0] vec, input logic [4:0] len, input int hold,
                         input bit spur, output logic [VW-1:0] resp, output int resp_cyc);
    int b;
    @(negedge CLK);
    req_vec = vec; req_len = len; req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    b = 0;
    while (!resp_valid && b < 2000) begin
      @(negedge CLK);
      b++;
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_valid, required within 2000 cycles");
      resp = '0; resp_cyc = -1;
      return;
    end
    resp = resp_vec;
    resp_cyc = cyc;
    for (int i = 0; i < hold; i++) begin
      if (spur && i == 1) spur_req = 1'b1;
      @(negedge CLK);
      chk("done_hold", {resp_vec, req_ready, resp_valid, vx_ready_out}, {resp, 1'b0, 1'b1, 1'b0});
    end
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [VW-1:0] vec;
    logic [4:0]    len;
    logic [VW-1:0] expv;
    int            n;
  } vec_t;

  initial begin
    vec_t tbl[4];
    logic [VW-1:0] mix, resp, rv;
    int rc, n, b;
    logic [4:0] rl;

    for (int i = 0; i < NL; i++)
      mix[i*DW +: DW] = {1'(i % 2), 8'(124 + i % 6), 7'(i * 9)};
    tbl[0] = '{'0, 5'd16, {16{16'h3F80}}, 16};
    tbl[1] = '{{208'h0, 16'hBF80, 16'h3F80, 16'h0000}, 5'd3,
               {208'h0, 16'h3EBC, 16'h402E, 16'h3F80}, 3};
    tbl[2] = '{mix, 5'd0, '0, 0};
    tbl[3] = '{mix, 5'd20, ref_resp(mix, 16), 16};

    // Reset state
    repeat (2) @(negedge CLK);
    chk("reset_outs", {req_ready, resp_valid, vx_valid_in, vx_ready_out, vx_operand},
        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    chk("reset_resp", resp_vec, '0);
    nRST = 1'b1;

    // Vector table, exp unit always ready
    for (int k = 0; k < 4; k++) begin
      run_req(tbl[k].vec, tbl[k].len, 0, 1'b0, resp, rc);
      chk($sformatf("tbl%0d_resp", k), resp, tbl[k].expv);
      chk($sformatf("tbl%0d_issues", k), n_iss, tbl[k].n);
      if (tbl[k].n == 0) begin
        chk($sformatf("tbl%0d_lat", k), rc, hs_cyc + 1);
      end else begin
        chk($sformatf("tbl%0d_lat", k), rc, last_cap + 1);
        chk($sformatf("tbl%0d_first_iss", k), first_iss, hs_cyc + 1);
        chk($sformatf("tbl%0d_consec", k), last_iss - first_iss, tbl[k].n - 1);
      end
    end

    // 4-cycle exp-unit stall after the 2nd issue
    stall_val = mix[2*DW +: DW];
    stall_en = 1'b1; stall_chk_en = 1'b1;
    run_req(tbl[3].vec, tbl[3].len, 0, 1'b0, resp, rc);
    stall_chk_en = 1'b0;
    chk("stall_resp", resp, tbl[3].expv);
    chk("stall_issues", n_iss, 16);

    // Spurious result while idle must not shift the next request
    spur_req = 1'b1;
    repeat (2) @(negedge CLK);
    run_req(tbl[1].vec, tbl[1].len, 5, 1'b1, resp, rc);
    chk("hold_resp", resp, tbl[1].expv);

    // Reset with two elements in flight
    @(negedge CLK);
    req_vec = mix; req_len = 5'd16; req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    b = 0;
    while (n_iss < 2 && b < 50) begin
      @(negedge CLK);
      b++;
    end
    chk("rst_inflight", n_iss - n_cap, 2);
    nRST = 1'b0;
    #1;
    chk("rst_async", {req_ready, vx_valid_in, vx_ready_out, resp_valid, vx_operand},
        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    @(negedge CLK);
    nRST = 1'b1;
    run_req(tbl[1].vec, tbl[1].len, 0, 1'b0, resp, rc);
    chk("post_rst_resp", resp, tbl[1].expv);
    chk("post_rst_issues", n_iss, 3);

    // Randomized requests with random exp-unit readiness
    rand_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NL; i++)
        rv[i*DW +: DW] = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 130)), 7'($urandom)};
      rl = 5'($urandom_range(0, 20));
      n = (int'(rl) > NL) ? NL : int'(rl);
      run_req(rv, rl, int'($urandom_range(0, 3)), 1'b0, resp, rc);
      chk($sformatf("rand%0d_resp", t), resp, ref_resp(rv, n));
      chk($sformatf("rand%0d_issues", t), n_iss, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vexp_seq.md
VEXP_SEQ -- requirements
Module: vexp_seq

Interface
REQ-001 SHALL provide parameter NUM_LANES, default 16: elements per vector request.
REQ-002 SHALL provide parameter DW, default 16: element width in bits (bf16).
REQ-003 SHALL provide port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port nRST  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port req_valid  input  1  vector request valid.
REQ-006 SHALL provide port req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL provide port req_vec  input  NUM_LANES*DW  operand vector; lane i at bits [i*DW +: DW].
REQ-008 SHALL provide port req_len  input  $clog2(NUM_LANES)+1  active element count.
REQ-009 SHALL provide port resp_valid  output  1  result vector valid.
REQ-010 SHALL provide port resp_ready  input  1  consumer accepts the result vector.
REQ-011 SHALL provide port resp_vec  output  NUM_LANES*DW  result vector, same lane packing as req_vec.
REQ-012 SHALL provide port vx_operand  output  DW  element to the exp unit (drives its operand).
REQ-013 SHALL provide port vx_valid_in  output  1  element valid to the exp unit.
REQ-014 SHALL provide port vx_ready_in  input  1  exp unit accepts an operand.
REQ-015 SHALL provide port vx_result  input  DW  result from the exp unit.
REQ-016 SHALL provide port vx_valid_out  input  1  exp unit result valid.
REQ-017 SHALL provide port vx_ready_out  output  1  sequencer accepts a result.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 SHALL assert req_ready only in IDLE; a request handshake is req_valid && req_ready.
REQ-020 SHALL, on request handshake, latch req_vec, latch n = min(req_len, NUM_LANES), clear iss_idx, res_idx and the result buffer, and enter RUN; if n == 0, enter DONE instead.
REQ-021 SHALL, in RUN, drive vx_valid_in = (iss_idx < n) and vx_operand = latched lane iss_idx; vx_operand SHALL hold stable while vx_valid_in && !vx_ready_in.
REQ-022 SHALL increment iss_idx on each vx_valid_in && vx_ready_in, issuing at most one element per cycle.
REQ-023 SHALL drive vx_ready_out = 1 in RUN and 0 in IDLE and DONE.
REQ-024 SHALL, on vx_valid_out && vx_ready_out, write vx_result into buffer lane res_idx and increment res_idx; results are in issue order.
REQ-025 SHALL allow an issue handshake and a result capture in the same cycle, including the final issue.
REQ-026 SHALL leave lanes >= n at 0x0000 in resp_vec.
REQ-027 SHALL transition RUN -> DONE on the cycle the capture making res_idx == n occurs.
REQ-028 SHALL assert resp_valid only in DONE and hold resp_vec stable until resp_ready; DONE -> IDLE on resp_valid && resp_ready.
REQ-029 SHALL ignore vx_valid_out in IDLE and DONE, with no buffer write and no counter change.
REQ-030 SHALL set latency from request handshake at cycle t to first vx_valid_in at t+1, and from final capture at cycle c to resp_valid at c+1.
REQ-031 SHALL never let res_idx exceed iss_idx; the in-flight count is iss_idx - res_idx.

Reset
REQ-032 SHALL, while nRST = 0, force IDLE, iss_idx = res_idx = 0, result buffer = 0, req_ready = 1, resp_valid = 0, vx_valid_in = 0, vx_ready_out = 0, vx_operand = 0.
REQ-033 SHALL discard in-flight elements on reset mid-RUN; the exp unit is reset by the same nRST.

Structure
REQ-034 SHALL place NUM_LANES, the bf16 width constant and the state enum typedef vexp_seq_state_t in vector_pkg.
REQ-035 SHALL connect to the exp unit through the existing vexp interface, with this block on the driving side.
REQ-036 SHALL be a single module; no sub-module is required.

Verification (bench uses a behavioural exp model with 3-cycle latency and randomizable ready_in)
REQ-037 Bench SHALL cover: req_vec all lanes 0x0000, req_len=16, vx_ready_in=1 -> 16 issues on consecutive cycles; resp_vec all 0x3F80; resp_valid 1 cycle after the 16th capture.
REQ-038 Bench SHALL cover: req_len=3, lanes 0..2 = 0x0000, 0x3F80, 0xBF80 -> resp lanes 0..2 = 0x3F80, 0x402E, 0x3EBC; lanes 3..15 = 0x0000; exactly 3 issues.
REQ-039 Bench SHALL cover: vx_ready_in low for 4 cycles after the 2nd issue -> vx_operand holds lane 2 value stable; final result identical to the no-stall run.
REQ-040 Bench SHALL cover: req_len=0 -> no vx_valid_in; resp_valid at t+1 with all-zero resp_vec.
REQ-041 Bench SHALL cover: resp_ready held low 5 cycles in DONE -> resp_vec stable, req_ready=0, and a spurious vx_valid_out pulse leaves the buffer unchanged.
REQ-042 Bench SHALL cover: nRST asserted with 2 elements in flight -> same cycle IDLE, req_ready=1, vx_valid_in=0; the next request completes correctly.
